// File: rtl/res_wb.sv
// res_wb: requantizes dp result vectors, packs them into activation
// words and writes them alternately to the even/odd activation banks.
module res_wb #(
    parameter int W     = 8,
    parameter int N     = 4,
    parameter int BG    = 8,
    parameter int AW    = 10,
    parameter int DEPTH = 4
) (
    input  logic                ck,
    input  logic                rst,
    input  logic                i_start,
    input  logic [3:0]          cfg_shift,
    input  logic                cfg_relu,
    input  logic [AW-1:0]       cfg_base,
    input  logic                cfg_bank0,
    input  logic [15:0]         cfg_nwords,
    input  logic                i_valid,
    input  logic [(N+BG)*W-1:0] i_data,
    output logic                o_wr_valid,
    input  logic                i_wr_ready,
    output logic [4*W-1:0]      o_wr_data,
    output logic [AW-1:0]       o_wr_addr,
    output logic                o_wr_even_odd_n,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_overflow
);
    localparam int L   = N + BG;
    localparam int XW  = L + 2;
    localparam int PW  = $clog2(DEPTH);
    localparam int PTW = PW + 1;
    localparam logic signed [XW-1:0] UMAX = XW'((1 << N) - 1);
    localparam logic signed [XW-1:0] SMAX = XW'((1 << (N - 1)) - 1);
    localparam logic signed [XW-1:0] SMIN = ~SMAX;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [3:0]         shift_q, shift_d;
    logic               relu_q, relu_d;
    logic [15:0]        nwords_q, nwords_d;
    logic [15:0]        wr_cnt_q, wr_cnt_d;
    logic [15:0]        in_cnt_q, in_cnt_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic               bank_q, bank_d;
    logic               pair_q, pair_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic               s1_vld_q, s1_vld_d;
    logic [N*W-1:0]     s1_q, s1_d;
    logic [N*W-1:0]     mem_q [DEPTH];
    logic [N*W-1:0]     mem_d [DEPTH];
    logic [PTW-1:0]     rd_q, rd_d;
    logic [PTW-1:0]     wr_q, wr_d;
    logic [N*W-1:0]     word;
    logic               fifo_vld;
    logic               full;
    logic               pop;

    // Headroom of two bits keeps the rounding add from wrapping at shift=11.
    function automatic logic [N-1:0] requant(input logic [L-1:0] x,
                                             input logic [3:0]   sh,
                                             input logic         relu);
        logic signed [XW-1:0] v;
        logic [N-1:0]         r;
        v = {{2{x[L-1]}}, x};
        if (sh != 4'd0) v = v + (XW'(1) << (sh - 4'd1));
        v = v >>> sh;
        if (relu) begin
            if (v[XW-1])      r = '0;
            else if (v > UMAX) r = UMAX[N-1:0];
            else               r = v[N-1:0];
        end else begin
            if (v < SMIN)      r = SMIN[N-1:0];
            else if (v > SMAX) r = SMAX[N-1:0];
            else               r = v[N-1:0];
        end
        return r;
    endfunction

    always_comb begin
        word = '0;
        for (int i = 0; i < W; i++)
            word[(W-1-i)*N +: N] = requant(i_data[(W-1-i)*L +: L], shift_q, relu_q);
    end

    assign fifo_vld = (wr_q != rd_q);
    assign full     = ((wr_q - rd_q) == PTW'(DEPTH));
    assign pop      = fifo_vld && i_wr_ready;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        relu_d   = relu_q;
        nwords_d = nwords_q;
        wr_cnt_d = wr_cnt_q;
        in_cnt_d = in_cnt_q;
        addr_d   = addr_q;
        bank_d   = bank_q;
        pair_d   = pair_q;
        busy_d   = busy_q;
        done_d   = done_q;
        ovf_d    = ovf_q;
        s1_vld_d = s1_vld_q;
        s1_d     = s1_q;
        mem_d    = mem_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        if (i_start) begin
            state_d  = RUN;
            shift_d  = cfg_shift;
            relu_d   = cfg_relu;
            nwords_d = cfg_nwords;
            addr_d   = cfg_base;
            bank_d   = cfg_bank0;
            pair_d   = 1'b0;
            wr_cnt_d = '0;
            in_cnt_d = '0;
            s1_vld_d = 1'b0;
            rd_d     = '0;
            wr_d     = '0;
            busy_d   = 1'b1;
            done_d   = 1'b0;
            ovf_d    = 1'b0;
        end else begin
            if (pop) begin
                rd_d     = rd_q + PTW'(1);
                bank_d   = ~bank_q;
                pair_d   = ~pair_q;
                wr_cnt_d = wr_cnt_q + 16'd1;
                if (pair_q) addr_d = addr_q + AW'(1);
            end
            // A full FIFO still accepts the S1 word when a pop frees a slot.
            if (s1_vld_q) begin
                if (!full || pop) begin
                    mem_d[wr_q[PW-1:0]] = s1_q;
                    wr_d = wr_q + PTW'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end
            s1_vld_d = 1'b0;
            if (state_q == RUN && i_valid && in_cnt_q != nwords_q) begin
                s1_vld_d = 1'b1;
                s1_d     = word;
                in_cnt_d = in_cnt_q + 16'd1;
            end
            case (state_q)
                RUN: begin
                    if (pop && (wr_cnt_q + 16'd1) == nwords_q) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            relu_q   <= 1'b0;
            nwords_q <= '0;
            wr_cnt_q <= '0;
            in_cnt_q <= '0;
            addr_q   <= '0;
            bank_q   <= 1'b0;
            pair_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            s1_vld_q <= 1'b0;
            s1_q     <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            relu_q   <= relu_d;
            nwords_q <= nwords_d;
            wr_cnt_q <= wr_cnt_d;
            in_cnt_q <= in_cnt_d;
            addr_q   <= addr_d;
            bank_q   <= bank_d;
            pair_q   <= pair_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            s1_vld_q <= s1_vld_d;
            s1_q     <= s1_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign o_wr_valid      = fifo_vld;
    assign o_wr_data       = fifo_vld ? mem_q[rd_q[PW-1:0]] : '0;
    assign o_wr_addr       = addr_q;
    assign o_wr_even_odd_n = bank_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_overflow      = ovf_q;

endmodule

// File: tb/tb_res_wb.sv
// tb_res_wb: requant vector table plus scoreboard-checked write
// sequences for res_wb (banking, backpressure, restart, reset).
module tb_res_wb;
    logic        ck = 1'b0;
    logic        rst = 1'b0;
    logic        i_start = 1'b0;
    logic [3:0]  cfg_shift = '0;
    logic        cfg_relu = 1'b0;
    logic [9:0]  cfg_base = '0;
    logic        cfg_bank0 = 1'b0;
    logic [15:0] cfg_nwords = '0;
    logic        i_valid = 1'b0;
    logic [95:0] i_data = '0;
    logic        o_wr_valid;
    logic        i_wr_ready = 1'b0;
    logic [31:0] o_wr_data;
    logic [9:0]  o_wr_addr;
    logic        o_wr_even_odd_n;
    logic        o_busy;
    logic        o_done;
    logic        o_overflow;

    res_wb dut (
        .ck(ck), .rst(rst), .i_start(i_start),
        .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .cfg_base(cfg_base),
        .cfg_bank0(cfg_bank0), .cfg_nwords(cfg_nwords),
        .i_valid(i_valid), .i_data(i_data),
        .o_wr_valid(o_wr_valid), .i_wr_ready(i_wr_ready),
        .o_wr_data(o_wr_data), .o_wr_addr(o_wr_addr),
        .o_wr_even_odd_n(o_wr_even_odd_n),
        .o_busy(o_busy), .o_done(o_done), .o_overflow(o_overflow)
    );

    always #5 ck = ~ck;

    typedef struct {
        logic [3:0]  sh;
        logic        relu;
        logic [95:0] data;
        logic [31:0] exp;
    } tv_t;

    typedef struct {
        logic [31:0] data;
        logic [9:0]  addr;
        logic        bank;
    } wr_t;

    tv_t  tv [6];
    wr_t  q [$];
    wr_t  h;
    logic hold_v = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   nwr = 0;
    int   cyc = 0;
    bit   rdy_mode = 1'b0;
    logic [9:0] m_addr;
    logic       m_bank;
    logic       m_pair;
    int         m_sh;
    bit         m_relu;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] mq(input logic [11:0] x, input int sh, input bit relu);
        int v, d, r;
        v = int'($signed(x));
        if (sh > 0) v = v + (1 << (sh - 1));
        d = 1 << sh;
        r = v / d;
        if ((v % d) != 0 && v < 0) r = r - 1;
        if (relu) begin
            if (r < 0) r = 0;
            if (r > 15) r = 15;
        end else begin
            if (r < -8) r = -8;
            if (r > 7) r = 7;
        end
        return 4'(r);
    endfunction

    function automatic logic [31:0] mword(input logic [95:0] d, input int sh, input bit relu);
        logic [31:0] w;
        w = '0;
        for (int j = 0; j < 8; j++) w[(7-j)*4 +: 4] = mq(d[(7-j)*12 +: 12], sh, relu);
        return w;
    endfunction

    function automatic logic [95:0] splat(input int v);
        logic [95:0] d;
        for (int j = 0; j < 8; j++) d[j*12 +: 12] = 12'(v);
        return d;
    endfunction

    task automatic tick();
        @(posedge ck);
        #1;
        cyc++;
        if (rdy_mode) i_wr_ready = (cyc % 3 != 2);
    endtask

    task automatic set_cfg(input logic [3:0] sh, input logic relu, input logic [9:0] base,
                           input logic bank, input logic [15:0] nw);
        cfg_shift = sh; cfg_relu = relu; cfg_base = base;
        cfg_bank0 = bank; cfg_nwords = nw;
        m_sh = int'(sh); m_relu = relu;
        m_addr = base; m_bank = bank; m_pair = 1'b0;
    endtask

    task automatic start(input logic [3:0] sh, input logic relu, input logic [9:0] base,
                         input logic bank, input logic [15:0] nw);
        set_cfg(sh, relu, base, bank, nw);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic push_model(input logic [31:0] w);
        wr_t e;
        e.data = w; e.addr = m_addr; e.bank = m_bank;
        q.push_back(e);
        if (m_pair) m_addr = m_addr + 10'd1;
        m_pair = ~m_pair;
        m_bank = ~m_bank;
    endtask

    task automatic send(input logic [95:0] d);
        i_valid = 1'b1;
        i_data = d;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic wait_empty(input string nm);
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        chk(nm, 64'(q.size()), 64'd0);
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!o_done && n < 20) begin
            tick();
            n++;
        end
        chk({nm, "_done"}, 64'(o_done), 64'd1);
        chk({nm, "_busy"}, 64'(o_busy), 64'd0);
        tick();
        chk({nm, "_pulse"}, 64'(o_done), 64'd0);
    endtask

    always @(negedge ck) begin
        wr_t e;
        if (rst && o_wr_valid) begin
            if (hold_v) begin
                chk("hold_data", 64'(o_wr_data), 64'(h.data));
                chk("hold_addr", 64'(o_wr_addr), 64'(h.addr));
                chk("hold_bank", 64'(o_wr_even_odd_n), 64'(h.bank));
            end
            if (i_wr_ready) begin
                hold_v = 1'b0;
                nwr++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got %0h at %0h expected none", o_wr_data, o_wr_addr);
                end else begin
                    e = q.pop_front();
                    chk("wr_data", 64'(o_wr_data), 64'(e.data));
                    chk("wr_addr", 64'(o_wr_addr), 64'(e.addr));
                    chk("wr_bank", 64'(o_wr_even_odd_n), 64'(e.bank));
                end
            end else begin
                hold_v = 1'b1;
                h.data = o_wr_data; h.addr = o_wr_addr; h.bank = o_wr_even_odd_n;
            end
        end else begin
            hold_v = 1'b0;
        end
    end

    initial begin
        logic [95:0] d;
        logic [9:0]  ba [5];
        logic        bb [5];
        int          n0;

        tv[0] = '{4'd4, 1'b1, {12'h064, 12'h0FF, 12'hF9C, 12'h064, 12'h064, 12'h064, 12'h064, 12'h064}, 32'h6F066666};
        tv[1] = '{4'd4, 1'b0, {12'h064, 12'h0FF, 12'hF9C, 12'h064, 12'h064, 12'h064, 12'h064, 12'h064}, 32'h67A66666};
        tv[2] = '{4'd0, 1'b0, {12'h000, 12'h001, 12'h007, 12'h008, 12'hFFF, 12'hFF8, 12'hFF7, 12'h800}, 32'h0177F888};
        tv[3] = '{4'd0, 1'b1, {12'h000, 12'h001, 12'h007, 12'h008, 12'hFFF, 12'hFF8, 12'hFF7, 12'h800}, 32'h01780000};
        tv[4] = '{4'd11, 1'b0, {12'h7FF, 12'h800, 12'h400, 12'h3FF, 12'hBFF, 12'hC00, 12'h000, 12'hFFF}, 32'h1F10F000};
        tv[5] = '{4'd1, 1'b1, {12'h001, 12'h002, 12'h003, 12'h01E, 12'h01F, 12'hFFF, 12'h020, 12'h00F}, 32'h112FF0F8};
        ba = '{10'h3FE, 10'h3FE, 10'h3FF, 10'h3FF, 10'h000};
        bb = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        tick();
        tick();
        chk("rst_valid", 64'(o_wr_valid), 64'd0);
        chk("rst_data", 64'(o_wr_data), 64'd0);
        chk("rst_addr", 64'(o_wr_addr), 64'd0);
        chk("rst_bank", 64'(o_wr_even_odd_n), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_ovf", 64'(o_overflow), 64'd0);
        rst = 1'b1;
        tick();

        i_valid = 1'b1;
        i_data = tv[0].data;
        tick();
        i_valid = 1'b0;
        chk("idle_ignore", 64'(o_wr_valid), 64'd0);
        tick();
        chk("idle_ignore2", 64'(o_wr_valid), 64'd0);

        start(4'd4, 1'b1, 10'h040, 1'b1, 16'd1);
        chk("start_busy", 64'(o_busy), 64'd1);
        i_wr_ready = 1'b1;
        push_model(32'h6F066666);
        i_valid = 1'b1;
        i_data = tv[0].data;
        tick();
        i_valid = 1'b0;
        chk("lat_k", 64'(o_wr_valid), 64'd0);
        tick();
        chk("lat_k1", 64'(o_wr_valid), 64'd1);
        tick();
        chk("lat_k2", 64'(o_wr_valid), 64'd0);
        chk("lat_done", 64'(o_done), 64'd1);
        tick();
        chk("lat_done_pulse", 64'(o_done), 64'd0);

        for (int i = 0; i < 6; i++) begin
            start(tv[i].sh, tv[i].relu, 10'(10'h010 + i), (i % 2 == 0), 16'd1);
            push_model(tv[i].exp);
            send(tv[i].data);
            wait_empty("tv_empty");
            wait_done("tv");
            chk("tv_ovf", 64'(o_overflow), 64'd0);
        end

        start(4'd0, 1'b0, 10'h3FE, 1'b0, 16'd5);
        for (int i = 0; i < 5; i++) begin
            wr_t e;
            d = splat(i);
            e.data = mword(d, 0, 1'b0);
            e.addr = ba[i];
            e.bank = bb[i];
            q.push_back(e);
            send(d);
        end
        wait_empty("seq_empty");
        wait_done("seq");

        rdy_mode = 1'b1;
        start(4'($urandom_range(0, 11)), 1'($urandom_range(0, 1)), 10'h1F0, 1'b1, 16'd8);
        for (int i = 0; i < 8; i++) begin
            d = {$urandom, $urandom, $urandom};
            push_model(mword(d, m_sh, m_relu));
            send(d);
            tick();
        end
        wait_empty("rnd_empty");
        wait_done("rnd");
        chk("rnd_ovf", 64'(o_overflow), 64'd0);
        rdy_mode = 1'b0;

        i_wr_ready = 1'b0;
        start(4'd0, 1'b0, 10'h020, 1'b1, 16'd6);
        for (int i = 0; i < 6; i++) begin
            d = splat(i + 1);
            if (i < 4) push_model(mword(d, 0, 1'b0));
            send(d);
        end
        tick();
        tick();
        tick();
        chk("bp_ovf", 64'(o_overflow), 64'd1);
        chk("bp_valid", 64'(o_wr_valid), 64'd1);
        n0 = nwr;
        i_wr_ready = 1'b1;
        repeat (10) tick();
        chk("bp_writes", 64'(nwr - n0), 64'd4);
        chk("bp_queue", 64'(q.size()), 64'd0);
        chk("bp_ovf_sticky", 64'(o_overflow), 64'd1);
        chk("bp_busy", 64'(o_busy), 64'd1);

        start(4'd0, 1'b0, 10'h100, 1'b1, 16'd5);
        chk("start_clr_ovf", 64'(o_overflow), 64'd0);
        for (int i = 0; i < 2; i++) begin
            d = splat(i + 2);
            push_model(mword(d, 0, 1'b0));
            send(d);
        end
        wait_empty("rs_first");
        i_wr_ready = 1'b0;
        send(splat(5));
        send(splat(6));
        tick();
        tick();
        chk("rs_pending", 64'(o_wr_valid), 64'd1);
        set_cfg(4'd0, 1'b0, 10'h200, 1'b0, 16'd3);
        i_start = 1'b1;
        i_valid = 1'b1;
        i_data = splat(7);
        tick();
        i_start = 1'b0;
        i_valid = 1'b0;
        q.delete();
        chk("rs_flush", 64'(o_wr_valid), 64'd0);
        chk("rs_addr", 64'(o_wr_addr), 64'h200);
        chk("rs_bank", 64'(o_wr_even_odd_n), 64'd0);
        chk("rs_busy", 64'(o_busy), 64'd1);
        i_wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rs_no_done", 64'(o_done), 64'd0);
            chk("rs_no_word", 64'(o_wr_valid), 64'd0);
        end
        for (int i = 0; i < 3; i++) begin
            d = splat(i);
            push_model(mword(d, 0, 1'b0));
            send(d);
        end
        wait_empty("rs_empty");
        wait_done("rs");

        i_wr_ready = 1'b0;
        start(4'd0, 1'b0, 10'h055, 1'b1, 16'd4);
        send(splat(1));
        send(splat(2));
        tick();
        chk("rr_valid", 64'(o_wr_valid), 64'd1);
        @(posedge ck);
        #3;
        rst = 1'b0;
        #1;
        chk("rr_valid0", 64'(o_wr_valid), 64'd0);
        chk("rr_data0", 64'(o_wr_data), 64'd0);
        chk("rr_addr0", 64'(o_wr_addr), 64'd0);
        chk("rr_bank0", 64'(o_wr_even_odd_n), 64'd0);
        chk("rr_busy0", 64'(o_busy), 64'd0);
        chk("rr_done0", 64'(o_done), 64'd0);
        chk("rr_ovf0", 64'(o_overflow), 64'd0);
        q.delete();
        tick();
        rst = 1'b1;
        i_wr_ready = 1'b1;
        tick();
        tick();
        chk("rr_after", 64'(o_wr_valid), 64'd0);
        chk("rr_after_busy", 64'(o_busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
